// File: rtl/spi_master_nch_pkg.sv
// spi_pkg: shared types and helpers for the spi_master_nch block.
//   state_t     - transfer FSM states
//   MODE0..3    - {CPOL,CPHA} encodings of the four SPI modes
//   cpol/cpha   - split a 2-bit mode into its clock polarity / phase
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic logic cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_master_nch_if.sv
// spi_master_nch_if: bundles the controller-side handshake and the SPI pins.
//   master modport - used by the SPI master itself
//   slave modport  - used by whatever drives the master (controller / bench)
// Signals: start/ready/done handshake, mode/lsb_first/div/ss_sel/tx_data
// config, rx_data result, sclk/mosi/miso/ss_n serial pins.
interface spi_master_nch_if
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8
);

  localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  logic              start;
  logic              ready;
  logic [1:0]        mode;
  logic              lsb_first;
  logic [DIV_W-1:0]  div;
  logic [SS_W-1:0]   ss_sel;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              done;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_SS-1:0] ss_n;

  modport master (
    input  start, mode, lsb_first, div, ss_sel, tx_data, miso,
    output ready, rx_data, done, sclk, mosi, ss_n
  );

  modport slave (
    output start, mode, lsb_first, div, ss_sel, tx_data, miso,
    input  ready, rx_data, done, sclk, mosi, ss_n
  );

endinterface

// File: rtl/spi_master_nch_clk_tick.sv
// spi_clk_tick: SCLK half-period timer.
//   clk, rst - system clock, synchronous active-high reset
//   load     - restart the count from zero (asserted when a transfer is accepted)
//   enable   - count while a transfer is in progress
//   div      - half-period is div+1 clk cycles
//   tick     - one-cycle pulse on the last cycle of every half-period
module spi_clk_tick
  import spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = enable && (cnt == div);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == div) ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_nch.sv
// spi_master_nch: SPI master with NUM_SS active-low selects, all four modes,
// MSB/LSB-first ordering and a programmable SCLK divider.
//   clk, rst - system clock, synchronous active-high reset
//   bus      - spi_master_nch_if.master: start/ready/done handshake, latched
//              config (mode, lsb_first, div, ss_sel, tx_data), rx_data result
//              and the sclk/mosi/miso/ss_n pins.
// All flops run on clk; sclk is a registered output only.
module spi_master_nch
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8
) (
  input  logic clk,
  input  logic rst,
  spi_master_nch_if.master bus
);

  localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

  state_t            state;
  logic [1:0]        mode_q;
  logic              lsb_q;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [EDGE_W-1:0] edge_cnt;
  logic              sample_pend;
  logic              ready_q;
  logic              done_q;
  logic [DATA_W-1:0] rx_q;
  logic              sclk_q;
  logic              mosi_q;
  logic [NUM_SS-1:0] ss_n_q;

  logic              tick;
  logic              accept;
  logic [EDGE_W-1:0] edge_next;
  logic              sample_edge;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_in;

  function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  // Out-of-range selects decode to all-high, so the transfer runs unselected.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (int'(sel) == i) v[i] = 1'b0;
    end
    return v;
  endfunction

  spi_clk_tick #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .enable (state != IDLE),
    .div    (div_q),
    .tick   (tick)
  );

  assign accept    = (state == IDLE) && bus.start;
  assign edge_next = edge_cnt + EDGE_W'(1);
  // Odd edges are leading; CPHA selects whether leading or trailing samples.
  assign sample_edge = cpha(mode_q) ? ~edge_next[0] : edge_next[0];
  assign tx_shift    = lsb_q ? (tx_sr >> 1) : (tx_sr << 1);

  // MISO is captured one cycle after the sample edge was launched, i.e. in the
  // cycle that edge is visible on sclk. With div=0 the final capture lands on
  // the same clk edge as the IDLE entry, so rx_data is loaded from rx_in.
  assign rx_in = !sample_pend ? rx_sr :
                 lsb_q        ? {bus.miso, rx_sr[DATA_W-1:1]} :
                                {rx_sr[DATA_W-2:0], bus.miso};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= '0;
      lsb_q       <= 1'b0;
      div_q       <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      edge_cnt    <= '0;
      sample_pend <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      rx_q        <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ss_n_q      <= '1;
    end else begin
      done_q      <= 1'b0;
      sample_pend <= 1'b0;
      rx_sr       <= rx_in;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          ss_n_q  <= '1;
          mosi_q  <= 1'b0;
          sclk_q  <= cpol(bus.mode);
          if (bus.start) begin
            mode_q   <= bus.mode;
            lsb_q    <= bus.lsb_first;
            div_q    <= bus.div;
            tx_sr    <= bus.tx_data;
            rx_sr    <= '0;
            edge_cnt <= '0;
            ss_n_q   <= ss_decode(bus.ss_sel);
            ready_q  <= 1'b0;
            // CPHA=0 slaves sample on the first edge, so bit 0 goes out now.
            mosi_q   <= cpha(bus.mode) ? 1'b0 : out_bit(bus.tx_data, bus.lsb_first);
            state    <= SETUP;
          end
        end
        SETUP, XFER: begin
          if (tick) begin
            sclk_q      <= ~sclk_q;
            edge_cnt    <= edge_next;
            sample_pend <= sample_edge;
            if (!sample_edge) begin
              // CPHA=1 presents bit 0 on edge 1 without shifting first.
              if (cpha(mode_q) && edge_cnt == '0) begin
                mosi_q <= out_bit(tx_sr, lsb_q);
              end else begin
                tx_sr  <= tx_shift;
                mosi_q <= out_bit(tx_shift, lsb_q);
              end
            end
            state <= (edge_next == LAST_EDGE) ? HOLD : XFER;
          end
        end
        HOLD: begin
          if (tick) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            rx_q    <= rx_in;
            ss_n_q  <= '1;
            mosi_q  <= 1'b0;
            sclk_q  <= cpol(mode_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.ss_n    = ss_n_q;

endmodule
